// File: rtl/vector_distance_unit_if.sv
// Element/result handshake bundle for vector_distance_unit.
// master drives element pairs and accepts results; slave is the engine.
interface vector_distance_unit_if #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [ELEM_W-1:0] in_a;
    logic signed [ELEM_W-1:0] in_b;
    logic [1:0]               mode;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_overflow;

    modport master (
        output in_valid, in_a, in_b, mode, out_ready,
        input  in_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, mode, out_ready,
        output in_ready, out_valid, out_data, out_overflow
    );
endinterface

// File: rtl/vector_distance_unit.sv
// Element-serial SSD / Euclid / dot / L1 engine with saturating accumulate.
// Optional VDU_MEAN_EN: divide the sum by VEC_LEN (toward zero) before output.
module vector_distance_unit #(
    parameter int ELEM_W  = 8,
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 32
) (
    input logic clk,
    input logic reset,
    vector_distance_unit_if.slave bus
);

    localparam int TW = 2 * ELEM_W + 2;
    localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;
    localparam int CW = $clog2(VEC_LEN);
    localparam int H  = ACC_W / 2;
    localparam int QW = $clog2(H);

    localparam logic [1:0] M_EUC = 2'b01;
    localparam logic [1:0] M_DOT = 2'b10;
    localparam logic [1:0] M_L1  = 2'b11;

    typedef enum logic [1:0] {
        S_ACCUM,
        S_SQRT,
        S_OUTPUT,
        S_MEAN
    } state_t;

    state_t state_q, state_d;

    logic signed [ACC_W-1:0] acc;
    logic                    ovf;
    logic [CW-1:0]           elem_cnt;
    logic [1:0]              mode_q;
    logic [H+1:0]            rem;
    logic [H-1:0]            root;
    logic [QW-1:0]           sq_cnt;
    logic signed [ACC_W-1:0] out_data_q;
    logic                    out_ovf_q;

    logic in_ready, out_valid, accept, last;
    logic [1:0] cur_mode;

    logic signed [ELEM_W:0]     d;
    logic [ELEM_W:0]            d_abs;
    logic signed [TW-1:0]       sq;
    logic signed [2*ELEM_W-1:0] prod;
    logic signed [TW-1:0]       term;
    logic signed [SW-1:0]       sum;
    logic [SW-ACC_W:0]          hi;
    logic                       fit;
    logic signed [ACC_W-1:0]    sat_val;
    logic signed [ACC_W-1:0]    acc_new;
    logic                       ovf_new;

    logic [H+3:0] rem_sh, trial;
    logic [H+1:0] rem_nx;
    logic [H-1:0] root_nx;

    assign accept   = bus.in_valid && in_ready;
    assign last     = elem_cnt == CW'(VEC_LEN - 1);
    assign cur_mode = (elem_cnt == '0) ? bus.mode : mode_q;

    // Per-element term selected by the effective (latched) mode.
    always_comb begin
        d = $signed({bus.in_a[ELEM_W-1], bus.in_a})
          - $signed({bus.in_b[ELEM_W-1], bus.in_b});
        d_abs = d[ELEM_W] ? 0 - d : d;
        sq    = d * d;
        prod  = bus.in_a * bus.in_b;
        term  = sq;
        unique case (cur_mode)
            M_DOT:   term = {{(TW-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
            M_L1:    term = {{(TW-ELEM_W-1){1'b0}}, d_abs};
            default: term = sq;
        endcase
    end

    // Wide add then clamp into the signed ACC_W range.
    always_comb begin
        sum = {{(SW-ACC_W){acc[ACC_W-1]}}, acc}
            + {{(SW-TW){term[TW-1]}}, term};
        hi  = sum[SW-1:ACC_W-1];
        fit = (&hi) || (~|hi);
        if (fit)
            sat_val = sum[ACC_W-1:0];
        else if (sum[SW-1])
            sat_val = {1'b1, {(ACC_W-1){1'b0}}};
        else
            sat_val = {1'b0, {(ACC_W-1){1'b1}}};
        acc_new = ovf ? acc : sat_val;
        ovf_new = ovf | ~fit;
    end

    // One restoring sqrt step; acc is the radicand shift register.
    always_comb begin
        rem_sh  = {rem, acc[ACC_W-1 -: 2]};
        trial   = {2'b00, root, 2'b01};
        rem_nx  = rem_sh[H+1:0];
        root_nx = {root[H-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh[H+1:0] - trial[H+1:0];
            root_nx = {root[H-2:0], 1'b1};
        end
    end

`ifdef VDU_MEAN_EN
    localparam int SH = $clog2(VEC_LEN);
    logic signed [ACC_W-1:0] bias, acc_b, acc_mean;

    // Bias negatives so the arithmetic shift truncates toward zero.
    always_comb begin
        bias     = acc[ACC_W-1] ? ACC_W'(VEC_LEN - 1) : ACC_W'(0);
        acc_b    = acc + bias;
        acc_mean = acc_b >>> SH;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_ACCUM;
        else
            state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_ACCUM: begin
                in_ready = !reset;
                if (bus.in_valid && last) begin
`ifdef VDU_MEAN_EN
                    state_d = S_MEAN;
`else
                    state_d = (cur_mode == M_EUC) ? S_SQRT : S_OUTPUT;
`endif
                end
            end
            S_SQRT: begin
                if (sq_cnt == QW'(H - 1))
                    state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (bus.out_ready)
                    state_d = S_ACCUM;
            end
`ifdef VDU_MEAN_EN
            S_MEAN: begin
                state_d = (mode_q == M_EUC) ? S_SQRT : S_OUTPUT;
            end
`endif
            default: state_d = S_ACCUM;
        endcase
    end

    // Accumulator, sqrt and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            ovf        <= 1'b0;
            elem_cnt   <= '0;
            mode_q     <= '0;
            rem        <= '0;
            root       <= '0;
            sq_cnt     <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        acc      <= acc_new;
                        ovf      <= ovf_new;
                        elem_cnt <= last ? '0 : elem_cnt + CW'(1);
                        if (elem_cnt == '0)
                            mode_q <= bus.mode;
                        if (last) begin
                            rem    <= '0;
                            root   <= '0;
                            sq_cnt <= '0;
`ifndef VDU_MEAN_EN
                            if (cur_mode != M_EUC) begin
                                out_data_q <= acc_new;
                                out_ovf_q  <= ovf_new;
                            end
`endif
                        end
                    end
                end
                S_SQRT: begin
                    acc    <= acc << 2;
                    rem    <= rem_nx;
                    root   <= root_nx;
                    sq_cnt <= sq_cnt + QW'(1);
                    if (sq_cnt == QW'(H - 1)) begin
                        out_data_q <= {{(ACC_W-H){1'b0}}, root_nx};
                        out_ovf_q  <= ovf;
                    end
                end
                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                end
`ifdef VDU_MEAN_EN
                S_MEAN: begin
                    acc <= acc_mean;
                    if (mode_q != M_EUC) begin
                        out_data_q <= acc_mean;
                        out_ovf_q  <= ovf;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_vector_distance_unit.sv
// Directed bench for vector_distance_unit (VEC_LEN=4, ACC_W=32 and 16).
// Expected values are hand-computed; VDU_MEAN_EN switches the expectations.
module tb_vector_distance_unit;

`ifdef VDU_MEAN_EN
    localparam int MEAN = 1;
`else
    localparam int MEAN = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              sel = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_a = '0;
    logic signed [7:0] in_b = '0;
    logic [1:0]        mode = '0;
    logic              out_ready = 1'b0;

    vector_distance_unit_if #(.ELEM_W(8), .ACC_W(32)) if0 ();
    vector_distance_unit_if #(.ELEM_W(8), .ACC_W(16)) if1 ();

    assign if0.in_valid  = in_valid & ~sel;
    assign if0.in_a      = in_a;
    assign if0.in_b      = in_b;
    assign if0.mode      = mode;
    assign if0.out_ready = out_ready & ~sel;
    assign if1.in_valid  = in_valid & sel;
    assign if1.in_a      = in_a;
    assign if1.in_b      = in_b;
    assign if1.mode      = mode;
    assign if1.out_ready = out_ready & sel;

    vector_distance_unit #(.ELEM_W(8), .VEC_LEN(4), .ACC_W(32)) u0 (
        .clk(clk), .reset(reset), .bus(if0.slave)
    );
    vector_distance_unit #(.ELEM_W(8), .VEC_LEN(4), .ACC_W(16)) u1 (
        .clk(clk), .reset(reset), .bus(if1.slave)
    );

    logic               in_ready_s, out_valid_s, out_ovf_s;
    logic signed [31:0] out_data_s;
    assign in_ready_s  = sel ? if1.in_ready : if0.in_ready;
    assign out_valid_s = sel ? if1.out_valid : if0.out_valid;
    assign out_ovf_s   = sel ? if1.out_overflow : if0.out_overflow;
    assign out_data_s  = sel ? {{16{if1.out_data[15]}}, if1.out_data}
                             : if0.out_data;

    int checks = 0;
    int fails  = 0;
    int lat;
    logic signed [31:0] res;
    logic               res_ovf;
    logic signed [7:0]  va [4];
    logic signed [7:0]  vb [4];

    task automatic send_elems(input logic [1:0] m0, input logic [1:0] mrest,
                              input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            mode = (i == 0) ? m0 : mrest;
            t = 0;
            @(negedge clk);
            while (!in_ready_s && t < 50) begin
                t++;
                @(negedge clk);
            end
            if (t >= 50) begin
                checks++; fails++;
                $display("FAIL accept_timeout: element %0d not accepted", i);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result();
        lat = 1;
        while (!out_valid_s && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_s) begin
            checks++; fails++;
            $display("FAIL result_timeout: out_valid never rose");
        end
        res = out_data_s;
        res_ovf = out_ovf_s;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic set_common();
        va = '{8'sd3, 8'sd5, -8'sd2, 8'sd10};
        vb = '{8'sd1, 8'sd1, 8'sd2, 8'sd7};
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready_s !== 1'b0) begin
            fails++; $display("FAIL rst_in_ready: got %b need 0", in_ready_s);
        end
        checks++;
        if (out_valid_s !== 1'b0) begin
            fails++; $display("FAIL rst_out_valid: got %b need 0", out_valid_s);
        end
        checks++;
        if (out_data_s !== 32'sd0) begin
            fails++; $display("FAIL rst_out_data: got %0d need 0", out_data_s);
        end
        checks++;
        if (out_ovf_s !== 1'b0) begin
            fails++; $display("FAIL rst_ovf: got %b need 0", out_ovf_s);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready_s !== 1'b1) begin
            fails++; $display("FAIL rst_release_ready: got %b need 1", in_ready_s);
        end
    endtask

    task automatic test_ssd();
        set_common();
        send_elems(2'b00, 2'b00, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd11 : 32'sd45)) begin
            fails++; $display("FAIL ssd_data: got %0d need %0d", res, MEAN ? 11 : 45);
        end
        checks++;
        if (res_ovf !== 1'b0) begin
            fails++; $display("FAIL ssd_ovf: got %b need 0", res_ovf);
        end
        checks++;
        if (lat != 1 + MEAN) begin
            fails++; $display("FAIL ssd_latency: got %0d need %0d", lat, 1 + MEAN);
        end
    endtask

    task automatic test_euclid();
        set_common();
        send_elems(2'b01, 2'b01, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd3 : 32'sd6)) begin
            fails++; $display("FAIL euclid_data: got %0d need %0d", res, MEAN ? 3 : 6);
        end
        checks++;
        if (lat != 17 + MEAN) begin
            fails++; $display("FAIL euclid_latency: got %0d need %0d", lat, 17 + MEAN);
        end
    endtask

    task automatic test_l1();
        set_common();
        send_elems(2'b11, 2'b11, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd3 : 32'sd13)) begin
            fails++; $display("FAIL l1_data: got %0d need %0d", res, MEAN ? 3 : 13);
        end
        checks++;
        if (lat != 1 + MEAN) begin
            fails++; $display("FAIL l1_latency: got %0d need %0d", lat, 1 + MEAN);
        end
        va = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        vb = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        send_elems(2'b11, 2'b11, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd255 : 32'sd1020)) begin
            fails++; $display("FAIL l1_wide_diff: got %0d need %0d", res, MEAN ? 255 : 1020);
        end
    endtask

    task automatic test_dot();
        va = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        vb = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        send_elems(2'b10, 2'b10, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd16384 : 32'sd65536)) begin
            fails++; $display("FAIL dot_data: got %0d need %0d", res, MEAN ? 16384 : 65536);
        end
        send_elems(2'b10, 2'b00, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd16384 : 32'sd65536)) begin
            fails++; $display("FAIL mode_latch: got %0d need %0d", res, MEAN ? 16384 : 65536);
        end
        va = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        vb = '{-8'sd1, -8'sd1, -8'sd1, -8'sd2};
        send_elems(2'b10, 2'b10, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? -32'sd1 : -32'sd5)) begin
            fails++; $display("FAIL dot_negative: got %0d need %0d", res, MEAN ? -1 : -5);
        end
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        va = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        vb = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        send_elems(2'b00, 2'b00, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd8191 : 32'sd32767)) begin
            fails++; $display("FAIL ovf_data: got %0d need %0d", res, MEAN ? 8191 : 32767);
        end
        checks++;
        if (res_ovf !== 1'b1) begin
            fails++; $display("FAIL ovf_flag: got %b need 1", res_ovf);
        end
        set_common();
        send_elems(2'b00, 2'b00, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd11 : 32'sd45)) begin
            fails++; $display("FAIL ovf_clean_data: got %0d need %0d", res, MEAN ? 11 : 45);
        end
        checks++;
        if (res_ovf !== 1'b0) begin
            fails++; $display("FAIL ovf_clean_flag: got %b need 0", res_ovf);
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int t;
        set_common();
        send_elems(2'b00, 2'b00, 4);
        t = 0;
        while (!out_valid_s && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b1;
        in_a = 8'sd9;
        in_b = 8'sd0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0 ||
                out_data_s !== (MEAN ? 32'sd11 : 32'sd45)) begin
                fails++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%0d need 1 0 %0d",
                         i, out_valid_s, in_ready_s, out_data_s, MEAN ? 11 : 45);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid_s !== 1'b0) begin
            fails++; $display("FAIL bp_valid_drop: got %b need 0", out_valid_s);
        end
        checks++;
        if (out_data_s !== (MEAN ? 32'sd11 : 32'sd45)) begin
            fails++; $display("FAIL bp_data_keep: got %0d need %0d", out_data_s, MEAN ? 11 : 45);
        end
    endtask

    task automatic test_back_to_back();
        set_common();
        send_elems(2'b00, 2'b00, 4);
        get_result();
        checks++;
        if (in_ready_s !== 1'b1) begin
            fails++; $display("FAIL b2b_ready: got %b need 1", in_ready_s);
        end
        send_elems(2'b11, 2'b11, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd3 : 32'sd13)) begin
            fails++; $display("FAIL b2b_data: got %0d need %0d", res, MEAN ? 3 : 13);
        end
    endtask

    task automatic test_reset_mid();
        set_common();
        send_elems(2'b00, 2'b00, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready_s !== 1'b0 || out_valid_s !== 1'b0) begin
            fails++; $display("FAIL mid_rst_outputs: ready=%b valid=%b need 0 0",
                              in_ready_s, out_valid_s);
        end
        reset = 1'b0;
        #1;
        send_elems(2'b00, 2'b00, 4);
        get_result();
        checks++;
        if (res !== (MEAN ? 32'sd11 : 32'sd45)) begin
            fails++; $display("FAIL mid_rst_data: got %0d need %0d", res, MEAN ? 11 : 45);
        end
    endtask

    initial begin
        test_reset();
        test_ssd();
        test_euclid();
        test_l1();
        test_dot();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
